// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS fetch/decode boundary
package mips_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    // Contents of the IF/ID pipeline register as seen by the decode stage.
    typedef struct packed {
        logic                  valid;
        logic [31:0]           instr;
        logic [ADDR_W_DEF-1:0] pc;
        logic [ADDR_W_DEF-1:0] pc4;
    } if_id_t;

    // Fetch FSM: RUN = normal fetch, PEND = redirect waiting for its delay slot.
    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_PEND = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register
//  clk, rst          : clock, synchronous active-high reset (all fields to zero)
//  hold              : keep contents (highest priority after rst)
//  load              : capture d_instr/d_pc/d_pc4 as a valid instruction
//  bubble            : invalidate; instr becomes NOP, pc/pc4 keep their values
//  valid/instr/pc/pc4: register outputs to decode
module if_id_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              bubble,
    input  logic              load,
    input  logic [31:0]       d_instr,
    input  logic [ADDR_W-1:0] d_pc,
    input  logic [ADDR_W-1:0] d_pc4,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
            pc4   <= '0;
        end else if (!hold) begin
            if (load) begin
                valid <= 1'b1;
                instr <= d_instr;
                pc    <= d_pc;
                pc4   <= d_pc4;
            end else if (bubble) begin
                valid <= 1'b0;
                instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, next-PC mux, IF/ID register
//  Optional feature macro: IF_DELAY_SLOT_EN (architectural branch delay slot, RUN/PEND FSM)
//  clk, rst                   : clock, synchronous active-high reset
//  imem_addr                  : fetch address (= pc)
//  imem_rdata, imem_ready     : instruction word and its valid qualifier
//  stall                      : hazard hold of pc and IF/ID
//  redirect_valid, redirect_pc: taken branch/jump target from ID
//  if_id_valid/instr/pc/pc4   : IF/ID register outputs to decode
module if_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc4
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redirect_tgt;
    logic              ifid_hold;
    logic              ifid_bubble;
    logic              ifid_load;
    logic              unused_redirect_lsb;

    assign imem_addr           = pc;
    assign pc_plus4            = pc + ADDR_W'(4);
    assign redirect_tgt        = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

`ifdef IF_DELAY_SLOT_EN
    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pend_pc;
    logic [ADDR_W-1:0] pend_pc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH_RUN;
            pend_pc <= '0;
        end else begin
            state   <= state_next;
            pend_pc <= pend_pc_next;
        end
    end

    // The word fetched in the redirect cycle is the delay slot and stays valid.
    // If memory is not ready, the target is parked and pc keeps pointing at the
    // slot until it arrives. A redirect in PEND cannot legally occur and is ignored.
    always_comb begin
        state_next   = state;
        pend_pc_next = pend_pc;
        pc_next      = pc;
        ifid_hold    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_load    = 1'b0;
        if (stall) begin
            ifid_hold = 1'b1;
        end else if (state == FETCH_PEND) begin
            if (imem_ready) begin
                ifid_load  = 1'b1;
                pc_next    = pend_pc;
                state_next = FETCH_RUN;
            end else begin
                ifid_bubble = 1'b1;
            end
        end else if (redirect_valid) begin
            if (imem_ready) begin
                ifid_load = 1'b1;
                pc_next   = redirect_tgt;
            end else begin
                ifid_bubble  = 1'b1;
                pend_pc_next = redirect_tgt;
                state_next   = FETCH_PEND;
            end
        end else if (imem_ready) begin
            ifid_load = 1'b1;
            pc_next   = pc_plus4;
        end else begin
            ifid_bubble = 1'b1;
        end
    end
`else
    // Without a delay slot the wrong-path word is squashed and the jump is
    // taken at once, whether or not memory answered this cycle.
    always_comb begin
        pc_next     = pc;
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_load   = 1'b0;
        if (stall) begin
            ifid_hold = 1'b1;
        end else if (redirect_valid) begin
            ifid_bubble = 1'b1;
            pc_next     = redirect_tgt;
        end else if (imem_ready) begin
            ifid_load = 1'b1;
            pc_next   = pc_plus4;
        end else begin
            ifid_bubble = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .hold    (ifid_hold),
        .bubble  (ifid_bubble),
        .load    (ifid_load),
        .d_instr (imem_rdata),
        .d_pc    (pc),
        .d_pc4   (pc_plus4),
        .valid   (if_id_valid),
        .instr   (if_id_instr),
        .pc      (if_id_pc),
        .pc4     (if_id_pc4)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected architectural state: next fetch address, IF/ID contents and
    // redirect targets still waiting for their delay slot.
    logic [31:0] m_pc;
    if_id_t      m_ifid;
    logic [31:0] pend_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a3c, a[31:16] + 16'h1234} ^ 32'h0f0f_0001;
    endfunction

    assign imem_rdata = rom(imem_addr);

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got=%08h exp=%08h", tag, $time, got, exp);
        end
    endtask

    function automatic if_id_t slot_of(input logic [31:0] a);
        if_id_t e;
        e.valid = 1'b1;
        e.instr = rom(a);
        e.pc    = a;
        e.pc4   = a + 32'd4;
        return e;
    endfunction

    task automatic squash();
        m_ifid.valid = 1'b0;
        m_ifid.instr = NOP_INSTR;
    endtask

    task automatic step(input logic r, input logic s, input logic rv,
                        input logic [31:0] rp, input logic rdy);
        logic [31:0] tgt;
        @(negedge clk);
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        imem_ready     = rdy;
        tgt            = rp & 32'hffff_fffc;
        if (r) begin
            m_pc   = RESET_PC_DEF;
            m_ifid = '0;
            pend_q.delete();
        end else if (s) begin
            // everything frozen
        end else if (pend_q.size() > 0) begin
            if (rdy) begin
                m_ifid = slot_of(m_pc);
                m_pc   = pend_q.pop_front();
            end else begin
                squash();
            end
        end else if (rv) begin
`ifdef IF_DELAY_SLOT_EN
            if (rdy) begin
                m_ifid = slot_of(m_pc);
                m_pc   = tgt;
            end else begin
                squash();
                pend_q.push_back(tgt);
            end
`else
            squash();
            m_pc = tgt;
`endif
        end else if (rdy) begin
            m_ifid = slot_of(m_pc);
            m_pc   = m_pc + 32'd4;
        end else begin
            squash();
        end
        @(posedge clk);
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_ifid.valid});
        chk("if_id_instr", if_id_instr, m_ifid.instr);
        chk("if_id_pc", if_id_pc, m_ifid.pc);
        chk("if_id_pc4", if_id_pc4, m_ifid.pc4);
    endtask

    initial begin
        logic        r, s, rv, rdy;
        logic [31:0] rp;

        // T1: reset then sequential fetch from 3000
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // T2: stall at 3008 for three cycles, then resume
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // T3: redirect with unaligned target at pc=3010
        step(0, 0, 1, 32'h0000_4002, 1);
        step(0, 0, 0, 0, 1);
        // T4: redirect while memory waits, then memory answers
        step(0, 0, 1, 32'h0000_5000, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // T5: stall masks a redirect; re-asserted redirect takes effect
        step(0, 1, 1, 32'h0000_6000, 1);
        step(0, 0, 1, 32'h0000_6000, 1);
        step(0, 0, 0, 0, 1);
        // T6: wrap from FFFF_FFFC to 0
        step(0, 0, 1, 32'hffff_fff8, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // reset while a redirect is parked
        step(0, 0, 1, 32'h0000_7000, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Randomised traffic; no redirect is issued while one is parked.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 4) == 0);
            rv  = ($urandom_range(0, 4) == 0) && (pend_q.size() == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rp  = ($urandom_range(0, 7) == 0) ? (32'hffff_fff0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(r, s, rv, rp, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
